// File: rtl/read_port_arbiter.sv
// read_port_arbiter: round-robin scheduler sharing one memory read port among NREQ requesters.
// Ports:
//   clock, reset_n       rising-edge clock, asynchronous active-low reset
//   req, req_addr        per-requester read requests and packed addresses (i at [i*AW +: AW])
//   gnt                  one-hot grant pulse, in ISSUE
//   mem_req, mem_addr    one-cycle read command to memory and its address
//   mem_rvalid, mem_rdata memory read return, sampled only in WAIT
//   rsp_valid, rsp_data  one-hot response strobe and registered data (holds last value)
//   rsp_err              response aborted by timeout, qualified by rsp_valid
//   busy                 high in any state except IDLE
// Optional feature macro: RD_TIMEOUT_EN (WAIT aborts after TIMEOUT_CYCLES cycles).
module read_port_arbiter #(
    parameter int NREQ           = 4,
    parameter int WIDTH          = 32,
    parameter int AW             = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_addr,
    output logic [NREQ-1:0]      gnt,
    output logic                 mem_req,
    output logic [AW-1:0]        mem_addr,
    input  logic                 mem_rvalid,
    input  logic [WIDTH-1:0]     mem_rdata,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [WIDTH-1:0]     rsp_data,
    output logic                 rsp_err,
    output logic                 busy
);
    localparam int OW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state, state_nx;
    logic [OW-1:0] owner, ptr, pick;
    logic          expire;

    // First set request at or after ptr, wrapping; scanning downward lets the
    // closest one to ptr overwrite the others.
    always_comb begin
        pick = ptr;
        for (int k = NREQ - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % NREQ]) pick = OW'((int'(ptr) + k) % NREQ);
    end

`ifdef RD_TIMEOUT_EN
    logic [15:0] cnt;
    logic        err;
    // Expiry on the cycle the counter would reach TIMEOUT_CYCLES.
    assign expire = !mem_rvalid && cnt == 16'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            cnt <= '0;
            err <= 1'b0;
        end else if (state == ISSUE) begin
            cnt <= '0;
        end else if (state == WAIT) begin
            cnt <= mem_rvalid ? cnt : cnt + 16'd1;
            err <= expire;
        end
`else
    logic err;
    assign expire = 1'b0;
    assign err    = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            state    <= IDLE;
            owner    <= '0;
            ptr      <= '0;
            mem_addr <= '0;
            rsp_data <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && |req) begin
                owner    <= pick;
                mem_addr <= req_addr[int'(pick)*AW +: AW];
            end
            if (state == ISSUE) ptr <= (owner == OW'(NREQ - 1)) ? '0 : owner + 1'b1;
            if (state == WAIT && mem_rvalid) rsp_data <= mem_rdata;
            else if (state == WAIT && expire) rsp_data <= '0;
        end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = |req ? ISSUE : IDLE;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = (mem_rvalid || expire) ? RESP : WAIT;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        gnt       = (state == ISSUE) ? NREQ'(1) << owner : '0;
        rsp_valid = (state == RESP) ? NREQ'(1) << owner : '0;
        mem_req   = state == ISSUE;
        rsp_err   = state == RESP && err;
        busy      = state != IDLE;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clock)
        if (reset_n) begin
            assert (!(state == IDLE && $isunknown(req))) else $error("req has X bits while IDLE");
            assert (NREQ >= 2 && NREQ <= 16 && TIMEOUT_CYCLES >= 1 && TIMEOUT_CYCLES <= 65535)
                else $error("read_port_arbiter parameter out of range");
        end
`endif
endmodule
